// File: rtl/wshb_arbiter_pkg.sv
// Shared types for the two-requester Wishbone arbiter: FSM states, one-hot
// owner encoding and the bundle of address/data fields held between grants.
package wshb_arbiter_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        OWN_MIRE = 2'd1,
        OWN_VGA  = 2'd2
    } state_t;

    typedef logic [1:0] owner_t;

    localparam owner_t OWNER_NONE = 2'b00;
    localparam owner_t OWNER_MIRE = 2'b01;
    localparam owner_t OWNER_VGA  = 2'b10;

    typedef struct packed {
        logic [ADR_W-1:0] adr;
        logic [SEL_W-1:0] sel;
        logic [2:0]       cti;
        logic [1:0]       bte;
        logic [DAT_W-1:0] datMs;
    } busFields_t;

    function automatic owner_t ownerOf(state_t s);
        case (s)
            OWN_MIRE: return OWNER_MIRE;
            OWN_VGA:  return OWNER_VGA;
            default:  return OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wshb_arbiter_if.sv
// Wishbone B4 classic bundle; master drives the cycle, slave returns ack and
// read data.
interface wshb_if;
    import wshb_arbiter_pkg::*;

    logic             cyc;
    logic             stb;
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [SEL_W-1:0] sel;
    logic [2:0]       cti;
    logic [1:0]       bte;
    logic [DAT_W-1:0] dat_ms;
    logic [DAT_W-1:0] dat_sm;
    logic             ack;

    modport master (
        output cyc, stb, we, adr, sel, cti, bte, dat_ms,
        input  dat_sm, ack
    );

    modport slave (
        input  cyc, stb, we, adr, sel, cti, bte, dat_ms,
        output dat_sm, ack
    );

endinterface

// File: rtl/wshb_arbiter_stats.sv
// Saturating grant and wait counters for the arbiter; only built when
// WSHB_ARBITER_STATS_EN is defined.
module wshb_arbiter_stats #(
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              grantMire,
    input  logic              grantVga,
    input  logic              vgaWaiting,
    output logic [STAT_W-1:0] gntCntMire,
    output logic [STAT_W-1:0] gntCntVga,
    output logic [STAT_W-1:0] waitCntVga
);

    localparam logic [STAT_W-1:0] CNT_MAX = '1;
    localparam logic [STAT_W-1:0] CNT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gntCntMire <= '0;
            gntCntVga  <= '0;
            waitCntVga <= '0;
        end else begin
            if (grantMire && gntCntMire != CNT_MAX) gntCntMire <= gntCntMire + CNT_ONE;
            if (grantVga  && gntCntVga  != CNT_MAX) gntCntVga  <= gntCntVga  + CNT_ONE;
            if (vgaWaiting && waitCntVga != CNT_MAX) waitCntVga <= waitCntVga + CNT_ONE;
        end
    end

endmodule

// File: rtl/wshb_arbiter.sv
// Two-requester Wishbone arbiter (mire pattern generator, vga display read)
// onto one SDRAM-side port. Optional counters under WSHB_ARBITER_STATS_EN.
//
// state    | meaning
// IDLE     | no owner; downstream cyc/stb/we low, bus fields held
// OWN_MIRE | mire owns the port until it drops cyc
// OWN_VGA  | vga owns the port until it drops cyc
module wshb_arbiter
    import wshb_arbiter_pkg::*;
#(
    parameter int VGA_PRIORITY = 1,
    parameter int STAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    wshb_if.slave             wshb_ifs_mire,
    wshb_if.slave             wshb_ifs_vga,
    wshb_if.master            wshb_ifm,
    output owner_t            owner,
    output logic [STAT_W-1:0] gnt_cnt_mire,
    output logic [STAT_W-1:0] gnt_cnt_vga,
    output logic [STAT_W-1:0] wait_cnt_vga
);

    state_t     state;
    state_t     stateNext;
    logic       lastVga;
    busFields_t heldQ;
    busFields_t busOut;
    busFields_t mireFields;
    busFields_t vgaFields;

    logic mireReq;
    logic vgaReq;

    assign mireReq = wshb_ifs_mire.cyc;
    assign vgaReq  = wshb_ifs_vga.cyc;

    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (mireReq && vgaReq)
                    stateNext = (VGA_PRIORITY != 0 || !lastVga) ? OWN_VGA : OWN_MIRE;
                else if (mireReq)
                    stateNext = OWN_MIRE;
                else if (vgaReq)
                    stateNext = OWN_VGA;
            end
            OWN_MIRE: if (!mireReq) stateNext = IDLE;
            OWN_VGA:  if (!vgaReq)  stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    // owner is registered from the next state so it tracks state cycle-exact
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            lastVga <= 1'b1;
            owner   <= OWNER_NONE;
            heldQ   <= '0;
        end else begin
            state <= stateNext;
            owner <= ownerOf(stateNext);
            heldQ <= busOut;
            if (stateNext == OWN_MIRE) lastVga <= 1'b0;
            if (stateNext == OWN_VGA)  lastVga <= 1'b1;
        end
    end

    assign mireFields = '{adr:   wshb_ifs_mire.adr,
                          sel:   wshb_ifs_mire.sel,
                          cti:   wshb_ifs_mire.cti,
                          bte:   wshb_ifs_mire.bte,
                          datMs: wshb_ifs_mire.dat_ms};

    assign vgaFields  = '{adr:   wshb_ifs_vga.adr,
                          sel:   wshb_ifs_vga.sel,
                          cti:   wshb_ifs_vga.cti,
                          bte:   wshb_ifs_vga.bte,
                          datMs: wshb_ifs_vga.dat_ms};

    always_comb begin
        wshb_ifm.cyc = 1'b0;
        wshb_ifm.stb = 1'b0;
        wshb_ifm.we  = 1'b0;
        busOut       = heldQ;
        case (state)
            OWN_MIRE: begin
                wshb_ifm.cyc = wshb_ifs_mire.cyc;
                wshb_ifm.stb = wshb_ifs_mire.stb;
                wshb_ifm.we  = wshb_ifs_mire.we;
                busOut       = mireFields;
            end
            OWN_VGA: begin
                wshb_ifm.cyc = wshb_ifs_vga.cyc;
                wshb_ifm.stb = wshb_ifs_vga.stb;
                wshb_ifm.we  = wshb_ifs_vga.we;
                busOut       = vgaFields;
            end
            default: ;
        endcase
    end

    assign wshb_ifm.adr    = busOut.adr;
    assign wshb_ifm.sel    = busOut.sel;
    assign wshb_ifm.cti    = busOut.cti;
    assign wshb_ifm.bte    = busOut.bte;
    assign wshb_ifm.dat_ms = busOut.datMs;

    assign wshb_ifs_mire.ack    = (state == OWN_MIRE) && wshb_ifm.ack;
    assign wshb_ifs_vga.ack     = (state == OWN_VGA)  && wshb_ifm.ack;
    assign wshb_ifs_mire.dat_sm = wshb_ifm.dat_sm;
    assign wshb_ifs_vga.dat_sm  = wshb_ifm.dat_sm;

`ifdef WSHB_ARBITER_STATS_EN
    logic grantMire;
    logic grantVga;
    logic vgaWaiting;

    assign grantMire  = (state != OWN_MIRE) && (stateNext == OWN_MIRE);
    assign grantVga   = (state != OWN_VGA)  && (stateNext == OWN_VGA);
    assign vgaWaiting = vgaReq && (state != OWN_VGA);

    wshb_arbiter_stats #(.STAT_W(STAT_W)) uStats (
        .clk        (clk),
        .rst_n      (rst_n),
        .grantMire  (grantMire),
        .grantVga   (grantVga),
        .vgaWaiting (vgaWaiting),
        .gntCntMire (gnt_cnt_mire),
        .gntCntVga  (gnt_cnt_vga),
        .waitCntVga (wait_cnt_vga)
    );
`else
    assign gnt_cnt_mire = '0;
    assign gnt_cnt_vga  = '0;
    assign wait_cnt_vga = '0;
`endif

endmodule

// File: tb/tb_wshb_arbiter.sv
// Bench for wshb_arbiter: a priority instance and a round-robin instance
// (STAT_W=4) share one stimulus and are checked against per-cycle models.
module tb_wshb_arbiter;
    import wshb_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        mCyc, mStb, mWe, vCyc, vStb, vWe, ackEn;
    logic [31:0] mAdr, mDat, vAdr, vDat;
    logic [3:0]  mSel, vSel;

    wshb_if mire[2] ();
    wshb_if vga[2] ();
    wshb_if ifm[2] ();

    for (genvar i = 0; i < 2; i++) begin : gDrive
        assign mire[i].cyc    = mCyc;
        assign mire[i].stb    = mStb;
        assign mire[i].we     = mWe;
        assign mire[i].adr    = mAdr;
        assign mire[i].sel    = mSel;
        assign mire[i].cti    = 3'b010;
        assign mire[i].bte    = 2'b00;
        assign mire[i].dat_ms = mDat;
        assign vga[i].cyc     = vCyc;
        assign vga[i].stb     = vStb;
        assign vga[i].we      = vWe;
        assign vga[i].adr     = vAdr;
        assign vga[i].sel     = vSel;
        assign vga[i].cti     = 3'b111;
        assign vga[i].bte     = 2'b01;
        assign vga[i].dat_ms  = vDat;
        assign ifm[i].ack     = ifm[i].cyc & ifm[i].stb & ackEn;
        assign ifm[i].dat_sm  = ~ifm[i].adr;
    end

    owner_t      ownP, ownR;
    logic [15:0] gmP, gvP, wvP;
    logic [3:0]  gmR, gvR, wvR;

    wshb_arbiter #(.VGA_PRIORITY(1), .STAT_W(16)) dutP (
        .clk(clk), .rst_n(rst_n), .wshb_ifs_mire(mire[0]), .wshb_ifs_vga(vga[0]),
        .wshb_ifm(ifm[0]), .owner(ownP), .gnt_cnt_mire(gmP), .gnt_cnt_vga(gvP),
        .wait_cnt_vga(wvP));

    wshb_arbiter #(.VGA_PRIORITY(0), .STAT_W(4)) dutR (
        .clk(clk), .rst_n(rst_n), .wshb_ifs_mire(mire[1]), .wshb_ifs_vga(vga[1]),
        .wshb_ifm(ifm[1]), .owner(ownR), .gnt_cnt_mire(gmR), .gnt_cnt_vga(gvR),
        .wait_cnt_vga(wvR));

    int vectors = 0;
    int miscompares = 0;

    // Model per instance: 0 = no owner, 1 = mire, 2 = vga
    int          mdlOwn[2];
    int          mdlLast[2];
    logic [31:0] mdlHeld[2];
    int          mdlGm[2], mdlGv[2], mdlWv[2];
    int          prio[2] = '{1, 0};
    int          cmax[2] = '{65535, 15};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mdlReset();
        for (int i = 0; i < 2; i++) begin
            mdlOwn[i] = 0; mdlLast[i] = 2; mdlHeld[i] = '0;
            mdlGm[i] = 0; mdlGv[i] = 0; mdlWv[i] = 0;
        end
    endtask

    task automatic modelEdge();
        int pick;
        if (!rst_n) begin
            mdlReset();
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (mdlOwn[i] != 0) mdlHeld[i] = (mdlOwn[i] == 1) ? mAdr : vAdr;
            if (vCyc && mdlOwn[i] != 2 && mdlWv[i] < cmax[i]) mdlWv[i]++;
            if (mdlOwn[i] == 1 && !mCyc) mdlOwn[i] = 0;
            else if (mdlOwn[i] == 2 && !vCyc) mdlOwn[i] = 0;
            else if (mdlOwn[i] == 0) begin
                pick = 0;
                if (mCyc && vCyc) pick = (prio[i] != 0) ? 2 : 3 - mdlLast[i];
                else if (mCyc) pick = 1;
                else if (vCyc) pick = 2;
                if (pick == 1 && mdlGm[i] < cmax[i]) mdlGm[i]++;
                if (pick == 2 && mdlGv[i] < cmax[i]) mdlGv[i]++;
                if (pick != 0) begin
                    mdlOwn[i] = pick;
                    mdlLast[i] = pick;
                end
            end
        end
    endtask

    task automatic checkOne(input int i, input string t, input owner_t own,
                            input logic cyc, input logic stb, input logic we,
                            input logic [31:0] adr, input logic [31:0] dsM, input logic [31:0] dsV,
                            input logic ackM, input logic ackV,
                            input logic [15:0] gm, input logic [15:0] gv, input logic [15:0] wv);
        int o = mdlOwn[i];
        logic eCyc, eStb, eWe, eAck;
        logic [31:0] eAdr;
        eCyc = (o == 1) ? mCyc : (o == 2) ? vCyc : 1'b0;
        eStb = (o == 1) ? mStb : (o == 2) ? vStb : 1'b0;
        eWe  = (o == 1) ? mWe  : (o == 2) ? vWe  : 1'b0;
        eAdr = (o == 1) ? mAdr : (o == 2) ? vAdr : mdlHeld[i];
        eAck = eCyc & eStb & ackEn;
        chk({t, " owner"}, 32'(own), (o == 1) ? 32'd1 : (o == 2) ? 32'd2 : 32'd0);
        chk({t, " ifm cyc/stb/we"}, {29'd0, cyc, stb, we}, {29'd0, eCyc, eStb, eWe});
        chk({t, " ifm adr"}, adr, eAdr);
        chk({t, " mire dat_sm"}, dsM, ~eAdr);
        chk({t, " vga dat_sm"}, dsV, ~eAdr);
        chk({t, " mire ack"}, 32'(ackM), 32'((o == 1) && eAck));
        chk({t, " vga ack"}, 32'(ackV), 32'((o == 2) && eAck));
`ifdef WSHB_ARBITER_STATS_EN
        chk({t, " gnt_cnt_mire"}, 32'(gm), 32'(mdlGm[i]));
        chk({t, " gnt_cnt_vga"}, 32'(gv), 32'(mdlGv[i]));
        chk({t, " wait_cnt_vga"}, 32'(wv), 32'(mdlWv[i]));
`else
        chk({t, " counters tied"}, {gm, gv | wv}, 32'd0);
`endif
    endtask

    task automatic checkAll();
        checkOne(0, "pri", ownP, ifm[0].cyc, ifm[0].stb, ifm[0].we, ifm[0].adr,
                 mire[0].dat_sm, vga[0].dat_sm, mire[0].ack, vga[0].ack, gmP, gvP, wvP);
        checkOne(1, "rr", ownR, ifm[1].cyc, ifm[1].stb, ifm[1].we, ifm[1].adr,
                 mire[1].dat_sm, vga[1].dat_sm, mire[1].ack, vga[1].ack,
                 {12'd0, gmR}, {12'd0, gvR}, {12'd0, wvR});
    endtask

    task automatic zeroCheck();
        chk("rst pri bus ctl", {21'd0, ifm[0].cyc, ifm[0].stb, ifm[0].we, ifm[0].sel, ifm[0].cti, ifm[0].bte}, 32'd0);
        chk("rst pri adr|dat", ifm[0].adr | ifm[0].dat_ms, 32'd0);
        chk("rst rr bus ctl", {21'd0, ifm[1].cyc, ifm[1].stb, ifm[1].we, ifm[1].sel, ifm[1].cti, ifm[1].bte}, 32'd0);
        chk("rst rr adr|dat", ifm[1].adr | ifm[1].dat_ms, 32'd0);
        chk("rst owners/acks", {26'd0, ownP, ownR, mire[0].ack | mire[1].ack, vga[0].ack | vga[1].ack}, 32'd0);
    endtask

    task automatic step();
        #1 checkAll();
        @(posedge clk);
        modelEdge();
        #1 checkAll();
    endtask

    task automatic rstPulse();
        rst_n = 1'b0;
        mdlReset();
        step();
        rst_n = 1'b1;
    endtask

    owner_t seq[$];
    owner_t prevOwn;
    owner_t rrExp[4] = '{OWNER_MIRE, OWNER_VGA, OWNER_MIRE, OWNER_VGA};
    int     mHold, vHold;

    initial begin
        mCyc = 0; mStb = 0; mWe = 0; mAdr = 32'h0; mDat = 32'h0; mSel = 4'h0;
        vCyc = 0; vStb = 0; vWe = 0; vAdr = 32'h0; vDat = 32'h0; vSel = 4'h0;
        ackEn = 1'b1;
        mdlReset();
        #2 zeroCheck();
        checkAll();
        step(); step();
        rst_n = 1'b1;

        // mire alone: four acked writes then release
        mCyc = 1; mStb = 1; mWe = 1; mSel = 4'hF; mAdr = 32'h100; mDat = 32'hA5A5_0001;
        step();
        for (int k = 1; k < 4; k++) begin
            mAdr = 32'h100 + 32'(4 * k); mDat = 32'hA5A5_0001 + 32'(k);
            step();
        end
        mCyc = 0; mStb = 0; mWe = 0;
        step(); step();

        // simultaneous requests, vga then mire after one idle cycle
        mCyc = 1; mStb = 1; vCyc = 1; vStb = 1; vAdr = 32'h2000; vSel = 4'h3;
        repeat (4) step();
        vCyc = 0; vStb = 0;
        repeat (3) step();
        mCyc = 0; mStb = 0;
        repeat (2) step();

        // continuous requests, 8-cycle holds: round-robin alternation
        rstPulse();
        mCyc = 1; mStb = 1; vCyc = 1; vStb = 1;
        mHold = 0; vHold = 0; prevOwn = OWNER_NONE;
        repeat (44) begin
            step();
            if (ownR != prevOwn && ownR != OWNER_NONE) seq.push_back(ownR);
            prevOwn = ownR;
            if (!mCyc) mCyc = 1'b1;
            else if (mdlOwn[1] == 1) begin
                mHold++;
                if (mHold == 8) begin mCyc = 1'b0; mHold = 0; end
            end
            if (!vCyc) vCyc = 1'b1;
            else if (mdlOwn[1] == 2) begin
                vHold++;
                if (vHold == 8) begin vCyc = 1'b0; vHold = 0; end
            end
        end
        chk("rr grant count", 32'(seq.size() >= 4), 32'd1);
        for (int k = 0; k < 4; k++)
            chk("rr grant order", 32'((k < seq.size()) ? seq[k] : 2'b11), 32'(rrExp[k]));
        mCyc = 0; vCyc = 0; mStb = 0; vStb = 0;
        repeat (2) step();

        // async reset on the third ack of a burst
        rstPulse();
        mCyc = 1; mStb = 1; mWe = 1; mAdr = 32'h3000;
        repeat (3) step();
        #2 rst_n = 1'b0;
        mdlReset();
        #1 zeroCheck();
        step();
        rst_n = 1'b1;
        step();
        chk("fresh grant pri", 32'(ownP), 32'(OWNER_MIRE));
        mCyc = 0; mStb = 0; mWe = 0;
        repeat (2) step();

        // vga waits ten cycles behind mire, then mire saturation
        rstPulse();
        mCyc = 1; mStb = 1;
        step();
        vCyc = 1; vStb = 1;
        repeat (8) step();
        mCyc = 0; mStb = 0;
        repeat (2) step();
`ifdef WSHB_ARBITER_STATS_EN
        chk("wait_cnt_vga pri", 32'(wvP), 32'd10);
        chk("wait_cnt_vga rr", 32'(wvR), 32'd10);
        chk("gnt_cnt_vga pri", 32'(gvP), 32'd1);
`else
        chk("stats off pri", {gmP, gvP | wvP}, 32'd0);
`endif
        vCyc = 0; vStb = 0;
        repeat (2) step();
        repeat (20) begin
            mCyc = 1; step();
            mCyc = 0; step();
        end
`ifdef WSHB_ARBITER_STATS_EN
        chk("gnt_cnt_mire sat rr", 32'(gmR), 32'd15);
        chk("gnt_cnt_mire pri", 32'(gmP), 32'd21);
`else
        chk("stats off rr", {20'd0, gmR, gvR, wvR}, 32'd0);
`endif

        // randomized traffic
        repeat (300) begin
            if ($urandom_range(0, 3) == 0) mCyc = ~mCyc;
            if ($urandom_range(0, 3) == 0) vCyc = ~vCyc;
            mStb = 1'($urandom); mWe = 1'($urandom); mAdr = $urandom; mDat = $urandom; mSel = 4'($urandom);
            vStb = 1'($urandom); vWe = 1'($urandom); vAdr = $urandom; vDat = $urandom; vSel = 4'($urandom);
            ackEn = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
